// File: rtl/conv_pkg.sv
// Shared constants and elaboration-time helpers for the convolution window MAC.
// Saturation bounds are returned as 64-bit values so any DATA_SIZE up to 64 fits.
package conv_pkg;

    localparam int DEFAULT_DATA_SIZE = 16;
    localparam int DEFAULT_FRAC_BITS = 8;

    // Number of registered levels needed to reduce n_in operands to one.
    function automatic int tree_depth(input int n_in);
        return (n_in > 1) ? $clog2(n_in) : 0;
    endfunction

    // Edges from window acceptance to pixel_valid:
    // multiply + tree levels + final stage.
    function automatic int calc_latency(input int kernel_size);
        return 2 + tree_depth(kernel_size * kernel_size);
    endfunction

    // Operands still alive after 'level' pairwise reductions; odd leftovers pass through.
    function automatic int level_count(input int n_in, input int level);
        int c;
        c = n_in;
        for (int i = 0; i < level; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Registered binary adder tree. Each level adds neighbouring operands pairwise and
// grows the word by one bit, so the sum can never overflow. A valid bit travels
// alongside the data. The tree needs at least two operands.
module mac_adder_tree
    import conv_pkg::*;
#(
    parameter int N_IN  = 9,
    parameter int IN_W  = 32,
    localparam int DEPTH = tree_depth(N_IN),
    localparam int OUT_W = IN_W + DEPTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    valid_i,
    input  logic [N_IN*IN_W-1:0]    operands_i,
    output logic                    valid_o,
    output logic signed [OUT_W-1:0] sum_o
);

    for (genvar l = 0; l < DEPTH; l++) begin : g_level
        localparam int N_SRC = level_count(N_IN, l);
        localparam int N_DST = level_count(N_IN, l + 1);
        localparam int SRC_W = IN_W + l;
        localparam int DST_W = SRC_W + 1;

        logic signed [SRC_W-1:0] src [N_SRC];
        logic signed [DST_W-1:0] sum [N_DST];
        logic                    src_valid;
        logic                    valid_q;

        if (l == 0) begin : g_first
            for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
                assign src[i] = $signed(operands_i[i*IN_W +: IN_W]);
            end
            assign src_valid = valid_i;
        end else begin : g_chain
            assign src       = g_level[l-1].sum;
            assign src_valid = g_level[l-1].valid_q;
        end

        // Level valid bit; cleared on reset so in-flight work is discarded.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= src_valid;
            end
        end

        for (genvar i = 0; i < N_DST; i++) begin : g_node
            logic signed [DST_W-1:0] node_q;

            if (2 * i + 1 < N_SRC) begin : g_pair
                // Sign-extend both operands one bit before adding them.
                always_ff @(posedge clock) begin
                    node_q <= DST_W'(src[2*i]) + DST_W'(src[2*i+1]);
                end
            end else begin : g_pass
                // Unpaired operand is carried forward so all paths share one latency.
                always_ff @(posedge clock) begin
                    node_q <= DST_W'(src[2*i]);
                end
            end

            assign sum[i] = node_q;
        end
    end

    assign sum_o   = g_level[DEPTH-1].sum[0];
    assign valid_o = g_level[DEPTH-1].valid_q;

endmodule

// File: rtl/conv_window_mac.sv
// KxK convolution window multiply-accumulate. A stream of K*K weights plus one
// bias is loaded first. Each accepted window is then multiplied, reduced by a
// registered adder tree, biased, rounded, rectified and saturated. One window
// is accepted per cycle, with no stalls.
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_SIZE   = DEFAULT_DATA_SIZE,
    parameter int FRAC_BITS   = DEFAULT_FRAC_BITS,
    parameter int RELU_EN     = 1
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        window_valid,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0] window_in,
    input  logic                                        weight_load,
    input  logic [DATA_SIZE-1:0]                        weight_in,
    output logic                                        weights_ready,
    output logic                                        pixel_valid,
    output logic [DATA_SIZE-1:0]                        pixel_out
);

    localparam int NUM_PIX = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PROD_W  = 2 * DATA_SIZE;
    localparam int DEPTH   = tree_depth(NUM_PIX);
    localparam int TREE_W  = PROD_W + DEPTH;
    localparam int ACC_W   = TREE_W + 2;
    localparam int CNT_W   = $clog2(NUM_PIX + 1);

    localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(DATA_SIZE));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(DATA_SIZE));

    logic signed [DATA_SIZE-1:0] weights_q [NUM_PIX];
    logic signed [DATA_SIZE-1:0] bias_q;
    logic [CNT_W-1:0]            load_cnt_q;
    logic                        weights_ready_q;
    logic                        accept;

    logic [NUM_PIX*PROD_W-1:0]   prod_d;
    logic [NUM_PIX*PROD_W-1:0]   prod_q;
    logic                        prod_valid_q;
    logic signed [DATA_SIZE-1:0] bias_pipe_q [DEPTH+1];

    logic                        tree_valid;
    logic signed [TREE_W-1:0]    tree_sum;

    logic signed [ACC_W-1:0]     acc_d;
    logic signed [ACC_W-1:0]     acc_q;
    logic                        acc_valid_q;
    logic signed [ACC_W-1:0]     shifted;
    logic [DATA_SIZE-1:0]        pixel_d;
    logic [DATA_SIZE-1:0]        pixel_out_q;
    logic                        pixel_valid_q;

    // Windows are only taken against a complete coefficient set (pre-edge state,
    // so a load in the same cycle does not affect this window).
    assign accept = window_valid & weights_ready_q;

    // Coefficient loader. Once a full set is loaded, the counter rests at zero,
    // so a load arriving while ready simply restarts the set at weight 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PIX; p++) begin
                weights_q[p] <= '0;
            end
            bias_q          <= '0;
            load_cnt_q      <= '0;
            weights_ready_q <= 1'b0;
        end else if (weight_load) begin
            if (load_cnt_q == CNT_W'(NUM_PIX)) begin
                bias_q          <= weight_in;
                load_cnt_q      <= '0;
                weights_ready_q <= 1'b1;
            end else begin
                weights_q[load_cnt_q] <= weight_in;
                load_cnt_q            <= load_cnt_q + 1'b1;
                weights_ready_q       <= 1'b0;
            end
        end
    end

    // Full-precision signed products of each pixel with its same-index weight.
    always_comb begin
        prod_d = '0;
        for (int p = 0; p < NUM_PIX; p++) begin
            prod_d[p*PROD_W +: PROD_W] = PROD_W'($signed(window_in[p*DATA_SIZE +: DATA_SIZE]))
                                       * PROD_W'(weights_q[p]);
        end
    end

    // Stage 1 product register; data needs no reset because the valid bit guards it.
    always_ff @(posedge clock) begin
        prod_q <= prod_d;
    end

    // Stage 1 valid, plus a bias delay line that keeps each window paired with the
    // bias it was accepted under even if a reload happens meanwhile.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prod_valid_q <= 1'b0;
            for (int i = 0; i <= DEPTH; i++) begin
                bias_pipe_q[i] <= '0;
            end
        end else begin
            prod_valid_q   <= accept;
            bias_pipe_q[0] <= bias_q;
            for (int i = 1; i <= DEPTH; i++) begin
                bias_pipe_q[i] <= bias_pipe_q[i-1];
            end
        end
    end

    mac_adder_tree #(
        .N_IN (NUM_PIX),
        .IN_W (PROD_W)
    ) u_tree (
        .clock      (clock),
        .reset      (reset),
        .valid_i    (prod_valid_q),
        .operands_i (prod_q),
        .valid_o    (tree_valid),
        .sum_o      (tree_sum)
    );

    // Bias is aligned to the product scale, then the half-LSB is added for round-half-up.
    always_comb begin
        acc_d = ACC_W'(tree_sum) + (ACC_W'(bias_pipe_q[DEPTH]) <<< FRAC_BITS) + ROUND_C;
    end

    // Biased accumulator register ahead of the rescale/clip step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_valid_q <= tree_valid;
        end
    end

    // Drop the fractional product bits, then rectify, then clip to the output range.
    always_comb begin
        shifted = acc_q >>> FRAC_BITS;
        pixel_d = DATA_SIZE'(shifted);
        if ((RELU_EN != 0) && shifted[ACC_W-1]) begin
            pixel_d = '0;
        end else if (shifted > SAT_MAX) begin
            pixel_d = DATA_SIZE'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            pixel_d = DATA_SIZE'(SAT_MIN);
        end
    end

    // Output register; the pixel value is held between results.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_out_q   <= '0;
            pixel_valid_q <= 1'b0;
        end else begin
            pixel_valid_q <= acc_valid_q;
            if (acc_valid_q) begin
                pixel_out_q <= pixel_d;
            end
        end
    end

    assign weights_ready = weights_ready_q;
    assign pixel_valid   = pixel_valid_q;
    assign pixel_out     = pixel_out_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Bench for conv_window_mac at the default parameters (3x3, Q8.8, ReLU on).
// Every cycle the outputs are compared with a behavioural model that computes
// each pixel with integer arithmetic and schedules it LAT edges after acceptance.
module tb_conv_window_mac;

    localparam int K     = 3;
    localparam int NP    = K * K;
    localparam int D     = 16;
    localparam int F     = 8;
    localparam int LAT   = 6;
    localparam longint SCALE = 256;

    typedef logic [D-1:0] word_arr_t [NP];
    typedef struct { int due; logic [D-1:0] val; } exp_t;
    typedef struct {
        logic [D-1:0] weight;
        logic [D-1:0] bias;
        logic [D-1:0] pix;
        logic [D-1:0] expect_out;
    } vec_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              window_valid;
    logic [NP*D-1:0]   window_in;
    logic              weight_load;
    logic [D-1:0]      weight_in;
    logic              weights_ready;
    logic              pixel_valid;
    logic [D-1:0]      pixel_out;

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int vcount = 0;
    int first_v = -1;
    int last_v  = -1;

    exp_t      exp_q [$];
    word_arr_t m_w;
    logic [D-1:0] m_b;
    bit        m_ready;
    word_arr_t pend_w;
    int        pend_n;
    logic [D-1:0] m_last;
    word_arr_t cur_pix;
    word_arr_t zero_arr;

    always #5 clock = ~clock;

    conv_window_mac #(
        .KERNEL_SIZE (K),
        .DATA_SIZE   (D),
        .FRAC_BITS   (F),
        .RELU_EN     (1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .window_valid  (window_valid),
        .window_in     (window_in),
        .weight_load   (weight_load),
        .weight_in     (weight_in),
        .weights_ready (weights_ready),
        .pixel_valid   (pixel_valid),
        .pixel_out     (pixel_out)
    );

    function automatic word_arr_t fill(input logic [D-1:0] v);
        word_arr_t a;
        for (int p = 0; p < NP; p++) a[p] = v;
        return a;
    endfunction

    function automatic logic [NP*D-1:0] pack(input word_arr_t a);
        logic [NP*D-1:0] r;
        for (int p = 0; p < NP; p++) r[p*D +: D] = a[p];
        return r;
    endfunction

    function automatic logic [D-1:0] rnd_word(input int range);
        int v;
        v = int'($urandom_range(0, 2 * range)) - range;
        return D'(v);
    endfunction

    // Real-valued convolution in integer form: sum of products at scale 2^(2F),
    // bias lifted to that scale, rounded half-up back to scale 2^F, ReLU, clip.
    function automatic logic [D-1:0] ref_pixel(input word_arr_t pix, input word_arr_t wts,
                                               input logic [D-1:0] b);
        longint s, r;
        s = 0;
        for (int p = 0; p < NP; p++) begin
            s += longint'($signed(pix[p])) * longint'($signed(wts[p]));
        end
        s += longint'($signed(b)) * SCALE + SCALE / 2;
        if (s >= 0) r = s / SCALE;
        else        r = -((-s + SCALE - 1) / SCALE);
        if (r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return D'(r);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic applyStimulus(input bit wv, input word_arr_t pix, input bit wl,
                                 input logic [D-1:0] w);
        window_valid = wv;
        cur_pix      = pix;
        window_in    = pack(pix);
        weight_load  = wl;
        weight_in    = w;
    endtask

    task automatic idle();
        applyStimulus(1'b0, zero_arr, 1'b0, '0);
    endtask

    // Per-cycle comparison of every output against the model.
    task automatic checkOutput();
        exp_t e;
        check("weights_ready", weights_ready, m_ready);
        if (pixel_valid === 1'b1) begin
            vcount++;
            if (first_v < 0) first_v = cycle;
            last_v = cycle;
        end
        if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
            e = exp_q.pop_front();
            check("pixel_valid", pixel_valid, 1);
            check("pixel_out", pixel_out, e.val);
            m_last = e.val;
        end else begin
            check("pixel_valid_idle", pixel_valid, 0);
            check("pixel_out_hold", pixel_out, m_last);
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge,
    // then compare outputs on the falling edge.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        cycle++;
        if (window_valid && m_ready) begin
            e.due = cycle + LAT;
            e.val = ref_pixel(cur_pix, m_w, m_b);
            exp_q.push_back(e);
        end
        if (weight_load) begin
            if (m_ready) begin
                m_ready = 1'b0;
                pend_n  = 0;
            end
            if (pend_n < NP) begin
                pend_w[pend_n] = weight_in;
                pend_n++;
            end else begin
                m_w     = pend_w;
                m_b     = weight_in;
                m_ready = 1'b1;
                pend_n  = 0;
            end
        end
        @(negedge clock);
        checkOutput();
    endtask

    task automatic load_set(input word_arr_t w, input logic [D-1:0] b);
        for (int p = 0; p < NP; p++) begin
            applyStimulus(1'b0, zero_arr, 1'b1, w[p]);
            tick();
        end
        applyStimulus(1'b0, zero_arr, 1'b1, b);
        tick();
        idle();
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_ready = 1'b0;
        pend_n  = 0;
        m_w     = zero_arr;
        m_b     = '0;
        m_last  = '0;
    endtask

    // Reset asserted mid-cycle, independent of the clock.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_pixel_out", pixel_out, 0);
        check("rst_weights_ready", weights_ready, 0);
        @(posedge clock);
        cycle++;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs [9];
        int   v0;
        word_arr_t wb;
        int   loads_left;
        bit   seen;
        int   lat_got;
        logic [D-1:0] got;

        vecs[0] = '{16'h0100, 16'h0000, 16'h0100, 16'h0900};
        vecs[1] = '{16'h0100, 16'h0000, 16'h7FFF, 16'h7FFF};
        vecs[2] = '{16'hFF00, 16'h0000, 16'h7FFF, 16'h0000};
        vecs[3] = '{16'h0000, 16'h0080, 16'h0000, 16'h0080};
        vecs[4] = '{16'h0080, 16'h0100, 16'h0300, 16'h0E80};
        vecs[5] = '{16'h0001, 16'h0000, 16'h0080, 16'h0005};
        vecs[6] = '{16'h0100, 16'hF000, 16'h0100, 16'h0000};
        vecs[7] = '{16'h0100, 16'h7FFF, 16'h0100, 16'h7FFF};
        vecs[8] = '{16'hFF80, 16'h0500, 16'h0100, 16'h0080};

        zero_arr = fill('0);
        reset = 1'b1;
        idle();
        model_clear();
        repeat (2) @(negedge clock);
        check("init_pixel_valid", pixel_valid, 0);
        check("init_pixel_out", pixel_out, 0);
        check("init_weights_ready", weights_ready, 0);
        reset = 1'b0;
        tick();

        // Directed vectors: uniform weights/pixels with hand-computed results.
        for (int i = 0; i < 9; i++) begin
            load_set(fill(vecs[i].weight), vecs[i].bias);
            applyStimulus(1'b1, fill(vecs[i].pix), 1'b0, '0);
            tick();
            idle();
            seen = 1'b0;
            lat_got = 0;
            got = '0;
            for (int t = 1; t <= LAT + 4; t++) begin
                tick();
                if (pixel_valid === 1'b1 && !seen) begin
                    seen = 1'b1;
                    lat_got = t;
                    got = pixel_out;
                end
            end
            check($sformatf("vec%0d_latency", i), lat_got, LAT);
            check($sformatf("vec%0d_value", i), got, vecs[i].expect_out);
        end

        // Reset three cycles after an accepted window: it must vanish.
        load_set(fill(16'h0100), 16'h0000);
        applyStimulus(1'b1, fill(16'h0200), 1'b0, '0);
        tick();
        idle();
        repeat (3) tick();
        async_reset();
        v0 = vcount;
        repeat (LAT + 4) tick();
        check("reset_inflight_dropped", vcount - v0, 0);

        // Windows offered during the first load are dropped; ready only after 10 loads.
        v0 = vcount;
        for (int p = 0; p < NP; p++) begin
            applyStimulus(1'b1, fill(16'h0100), 1'b1, 16'h0100);
            tick();
        end
        check("ready_after_9_loads", weights_ready, 0);
        applyStimulus(1'b1, fill(16'h0100), 1'b1, 16'h0000);
        tick();
        check("ready_after_10_loads", weights_ready, 1);
        idle();
        repeat (LAT + 3) tick();
        check("early_windows_dropped", vcount - v0, 0);

        // Twenty back-to-back windows must come out as twenty consecutive results.
        load_set(fill(16'h0100), 16'h0000);
        v0 = vcount;
        first_v = -1;
        last_v = -1;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1, fill(D'(k * 256)), 1'b0, '0);
            tick();
        end
        idle();
        repeat (LAT + 4) tick();
        check("burst_count", vcount - v0, 20);
        check("burst_contiguous", last_v - first_v + 1, 20);

        // Reload mid-stream: the overlap window uses the old set, later ones drop.
        load_set(fill(16'h0100), 16'h0000);
        for (int p = 0; p < NP; p++) wb[p] = rnd_word(16'h0200);
        v0 = vcount;
        for (int i = 0; i < 30; i++) begin
            if (i >= 5 && i < 5 + NP)
                applyStimulus(1'b1, fill(D'(i * 64)), 1'b1, wb[i-5]);
            else if (i == 5 + NP)
                applyStimulus(1'b1, fill(D'(i * 64)), 1'b1, 16'h0040);
            else
                applyStimulus(1'b1, fill(D'(i * 64)), 1'b0, '0);
            tick();
        end
        idle();
        repeat (LAT + 4) tick();
        check("reload_accepted_count", vcount - v0, 21);

        // Random traffic with occasional reloads that may have gaps between loads.
        for (int p = 0; p < NP; p++) wb[p] = rnd_word(16'h0200);
        load_set(wb, rnd_word(16'h0400));
        loads_left = 0;
        for (int c = 0; c < 400; c++) begin
            word_arr_t rp;
            bit wl;
            for (int p = 0; p < NP; p++) rp[p] = rnd_word(16'h0400);
            wl = 1'b0;
            if (loads_left > 0) begin
                wl = ($urandom_range(0, 2) != 0);
                if (wl) loads_left--;
            end else if ($urandom_range(0, 49) == 0) begin
                wl = 1'b1;
                loads_left = NP;
            end
            applyStimulus($urandom_range(0, 3) != 0, rp, wl,
                          (loads_left == 0 && wl) ? rnd_word(16'h0400) : rnd_word(16'h0200));
            tick();
        end
        idle();
        repeat (NP + 2) begin
            if (loads_left > 0) begin
                applyStimulus(1'b0, zero_arr, 1'b1, rnd_word(16'h0200));
                loads_left--;
            end else begin
                idle();
            end
            tick();
        end
        idle();
        repeat (LAT + 4) tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
